// File: rtl/merger_pkg.sv
// Shared types for the merge-pass leaf refill logic: pass FSM states and beat geometry.
package merger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } merger_state_e;

  localparam int BEAT_BYTES_DEFAULT = 16;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first requester strictly after ptr (wrapping) wins.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  // Scan from ptr+1 around to ptr, latching the first hit
  always_comb begin
    logic [PW-1:0] idx_v;
    logic          hit_v;
    grant = '0;
    valid = 1'b0;
    idx_v = '0;
    hit_v = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx_v        = PW'((int'(ptr) + i) % N);
      hit_v        = req[idx_v] & ~valid;
      grant[idx_v] = grant[idx_v] | hit_v;
      valid        = valid | hit_v;
    end
  end

endmodule

// File: rtl/leaf_refill_scheduler.sv
// Issues credit-limited beat reads that keep merger-tree leaf FIFOs topped up during a merge pass.
// Define LEAF_REFILL_STATS_EN to build the stall/request statistics counters.
module leaf_refill_scheduler
  import merger_pkg::*;
#(
  parameter  int NUM_LEAVES = 4,
  parameter  int FIFO_DEPTH = 8,
  parameter  int ADDR_WIDTH = 32,
  parameter  int LEN_WIDTH  = 32,
  parameter  int BEAT_BYTES = BEAT_BYTES_DEFAULT,
  localparam int TW = $clog2(NUM_LEAVES),
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int OW = $clog2(NUM_LEAVES * FIFO_DEPTH + 1)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  input  logic [NUM_LEAVES*ADDR_WIDTH-1:0] i_run_base,
  input  logic [NUM_LEAVES*LEN_WIDTH-1:0]  i_run_len,
  output logic                             o_rd_req_valid,
  input  logic                             i_rd_req_ready,
  output logic [ADDR_WIDTH-1:0]            o_rd_req_addr,
  output logic [TW-1:0]                    o_rd_req_tag,
  input  logic                             i_rd_resp_valid,
  input  logic [TW-1:0]                    i_rd_resp_tag,
  output logic [NUM_LEAVES-1:0]            o_leaf_enq,
  input  logic [NUM_LEAVES-1:0]            i_leaf_deq,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [31:0]                      o_stall_cycles,
  output logic [31:0]                      o_req_count
);

  merger_state_e         state_r, state_s;
  logic [ADDR_WIDTH-1:0] addr_r   [NUM_LEAVES];
  logic [LEN_WIDTH-1:0]  rem_r    [NUM_LEAVES];
  logic [CW-1:0]         credit_r [NUM_LEAVES];
  logic [OW-1:0]         outst_r;
  logic [TW-1:0]         ptr_r, lock_tag_r, grant_idx_s, sel_idx_s;
  logic                  lock_r;
  logic [NUM_LEAVES-1:0] elig_s, grant_s, take_s;
  logic                  grant_valid_s, all_zero_s, req_valid_s, accept_s, resp_s, load_s;

  // Leaf eligibility and end-of-data summary
  always_comb begin
    elig_s     = '0;
    all_zero_s = 1'b1;
    for (int k = 0; k < NUM_LEAVES; k++) begin
      elig_s[k]  = (rem_r[k] != '0) && (credit_r[k] != '0);
      all_zero_s = all_zero_s & (rem_r[k] == '0);
    end
  end

  rr_arbiter #(.N(NUM_LEAVES)) u_rr_arbiter (
    .req   (elig_s),
    .ptr   (ptr_r),
    .grant (grant_s),
    .valid (grant_valid_s)
  );

  // A stalled request keeps its leaf so late credit returns cannot re-steer it
  always_comb begin
    grant_idx_s = '0;
    for (int k = 0; k < NUM_LEAVES; k++) begin
      grant_idx_s = grant_idx_s | (grant_s[k] ? TW'(k) : '0);
    end
    sel_idx_s   = lock_r ? lock_tag_r : grant_idx_s;
    req_valid_s = (state_r == ST_RUN) && (lock_r || grant_valid_s);
    accept_s    = req_valid_s && i_rd_req_ready;
    resp_s      = i_rd_resp_valid && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    load_s      = (state_r == ST_IDLE) && i_start;
    for (int k = 0; k < NUM_LEAVES; k++) begin
      take_s[k] = accept_s && (sel_idx_s == TW'(k));
    end
  end

  // Response tag decode to leaf FIFO write strobe; deliberately ungated by reset or state
  always_comb begin
    o_leaf_enq = '0;
    for (int k = 0; k < NUM_LEAVES; k++) begin
      o_leaf_enq[k] = i_rd_resp_valid && (i_rd_resp_tag == TW'(k));
    end
  end

  assign o_rd_req_valid = req_valid_s;
  assign o_rd_req_addr  = addr_r[sel_idx_s];
  assign o_rd_req_tag   = sel_idx_s;
  assign o_busy         = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign o_done         = (state_r == ST_DONE);

  // Pass sequencing
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (i_start) state_s = ST_RUN; else state_s = ST_IDLE;
      ST_RUN:   if (all_zero_s) state_s = ST_DRAIN; else state_s = ST_RUN;
      ST_DRAIN: if (outst_r == '0) state_s = ST_DONE; else state_s = ST_DRAIN;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Control state, round-robin pointer and stall lock
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      lock_r     <= 1'b0;
      lock_tag_r <= '0;
    end else begin
      state_r    <= state_s;
      lock_r     <= req_valid_s && !i_rd_req_ready;
      lock_tag_r <= sel_idx_s;
      if (load_s) begin
        ptr_r <= TW'(NUM_LEAVES - 1);
      end else if (accept_s) begin
        ptr_r <= sel_idx_s;
      end
    end
  end

  // Per-leaf address, remaining length and FIFO credit
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_LEAVES; k++) begin
      if (!i_rst_n) begin
        addr_r[k]   <= '0;
        rem_r[k]    <= '0;
        credit_r[k] <= '0;
      end else if (load_s) begin
        addr_r[k]   <= i_run_base[k*ADDR_WIDTH +: ADDR_WIDTH];
        rem_r[k]    <= i_run_len[k*LEN_WIDTH +: LEN_WIDTH];
        credit_r[k] <= CW'(FIFO_DEPTH);
      end else begin
        if (take_s[k]) begin
          addr_r[k] <= addr_r[k] + ADDR_WIDTH'(BEAT_BYTES);
          rem_r[k]  <= rem_r[k] - LEN_WIDTH'(1);
        end
        if (take_s[k] && !i_leaf_deq[k]) begin
          credit_r[k] <= credit_r[k] - CW'(1);
        end else if (!take_s[k] && i_leaf_deq[k] && (credit_r[k] != CW'(FIFO_DEPTH))) begin
          credit_r[k] <= credit_r[k] + CW'(1);
        end
      end
    end
  end

  // Reads in flight; responses outside an active pass are stale and ignored
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      outst_r <= '0;
    end else if (accept_s && !resp_s) begin
      outst_r <= outst_r + OW'(1);
    end else if (resp_s && !accept_s && (outst_r != '0)) begin
      outst_r <= outst_r - OW'(1);
    end
  end

`ifdef LEAF_REFILL_STATS_EN
  logic [31:0] stall_cnt_r, req_cnt_r;

  // Pass statistics, restarted by each accepted start
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_r <= 32'd0;
      req_cnt_r   <= 32'd0;
    end else if (load_s) begin
      stall_cnt_r <= 32'd0;
      req_cnt_r   <= 32'd0;
    end else begin
      if (req_valid_s && !i_rd_req_ready) stall_cnt_r <= sat_inc32(stall_cnt_r);
      if (accept_s) req_cnt_r <= sat_inc32(req_cnt_r);
    end
  end

  assign o_stall_cycles = stall_cnt_r;
  assign o_req_count    = req_cnt_r;
`else
  assign o_stall_cycles = 32'd0;
  assign o_req_count    = 32'd0;
`endif

endmodule

// File: tb/tb_leaf_refill_scheduler.sv
// Directed bench for leaf_refill_scheduler: spec-level model checked every cycle plus literal pins.
module tb_leaf_refill_scheduler;
  localparam int NL = 4;
  localparam int DEPTH = 8;
  localparam int AW = 32;
  localparam int LW = 32;

  logic           clk = 1'b0;
  logic           rst_n, start, ready, resp_valid;
  logic [NL*AW-1:0] run_base;
  logic [NL*LW-1:0] run_len;
  logic [1:0]     resp_tag;
  logic [NL-1:0]  deq;
  logic           req_valid, busy, done;
  logic [AW-1:0]  req_addr;
  logic [1:0]     req_tag;
  logic [NL-1:0]  leaf_enq;
  logic [31:0]    stall_cycles, req_count;

  always #5 clk = ~clk;

  leaf_refill_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_run_base(run_base), .i_run_len(run_len),
    .o_rd_req_valid(req_valid), .i_rd_req_ready(ready), .o_rd_req_addr(req_addr), .o_rd_req_tag(req_tag),
    .i_rd_resp_valid(resp_valid), .i_rd_resp_tag(resp_tag), .o_leaf_enq(leaf_enq), .i_leaf_deq(deq),
    .o_busy(busy), .o_done(done), .o_stall_cycles(stall_cycles), .o_req_count(req_count)
  );

  // Model: phase 0 idle, 1 fetching, 2 waiting for data, 3 finished
  int            m_phase, m_out, m_last, m_stall, m_reqs, m_held_tag, m_acc_tag;
  int            m_rem [NL];
  int            m_cred[NL];
  logic [AW-1:0] m_addr[NL];
  bit            m_held, m_acc, e_valid, auto_resp;
  int            e_tag;

  int            checks = 0, failures = 0;
  logic [1:0]    dut_tags[$];
  logic [AW-1:0] dut_addrs[$];
  int            done_seen, done_at;
  bit            s_valid, s_busy, s_done;
  int            s_tag;
  logic [AW-1:0] s_addr;

  logic [1:0]    exp_tags1 [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [AW-1:0] exp_addrs1[12] = '{32'h1000, 32'h2000, 32'h3000, 32'hFFFF_FFF0,
                                    32'h1010, 32'h2010, 32'h3010, 32'h0000_0000,
                                    32'h1020, 32'h2020, 32'h3020, 32'h0000_0010};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model_expect();
    e_valid = 1'b0;
    e_tag   = 0;
    if (m_phase == 1) begin
      if (m_held) begin
        e_valid = 1'b1;
        e_tag   = m_held_tag;
      end else begin
        for (int i = 1; i <= NL; i++) begin
          int k;
          k = (m_last + i) % NL;
          if (!e_valid && m_rem[k] > 0 && m_cred[k] > 0) begin
            e_valid = 1'b1;
            e_tag   = k;
          end
        end
      end
    end
  endfunction

  task automatic compare();
    logic [NL-1:0] e_enq;
    model_expect();
    e_enq = resp_valid ? (NL'(1) << resp_tag) : '0;
    chk("req_valid", req_valid, e_valid);
    if (e_valid) begin
      chk("req_tag", req_tag, e_tag);
      chk("req_addr", req_addr, m_addr[e_tag]);
    end
    chk("busy", busy, (m_phase == 1) || (m_phase == 2));
    chk("done", done, m_phase == 3);
    chk("leaf_enq", leaf_enq, e_enq);
`ifdef LEAF_REFILL_STATS_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("req_count", req_count, m_reqs);
`else
    chk("stall_cycles_off", stall_cycles, 0);
    chk("req_count_off", req_count, 0);
`endif
  endtask

  task automatic model_update();
    bit acc, resp_live, all_zero, take;
    int nphase;
    acc = e_valid && ready;
    m_acc = acc;
    m_acc_tag = e_tag;
    if (!rst_n) begin
      m_phase = 0; m_out = 0; m_last = 0; m_stall = 0; m_reqs = 0; m_held = 0; m_acc = 0;
      for (int k = 0; k < NL; k++) m_rem[k] = 0;
      return;
    end
    all_zero = 1'b1;
    for (int k = 0; k < NL; k++) if (m_rem[k] != 0) all_zero = 1'b0;
    nphase = m_phase;
    case (m_phase)
      0: if (start) nphase = 1;
      1: if (all_zero) nphase = 2;
      2: if (m_out == 0) nphase = 3;
      default: nphase = 0;
    endcase
    resp_live = resp_valid && (m_phase == 1 || m_phase == 2);
    if (resp_live && !acc && m_out > 0) m_out--;
    if (acc && !resp_live) m_out++;
    if (e_valid && !ready) m_stall++;
    m_held = e_valid && !ready;
    m_held_tag = e_tag;
    for (int k = 0; k < NL; k++) begin
      take = acc && (e_tag == k);
      if (take && !deq[k]) m_cred[k]--;
      else if (deq[k] && !take && m_cred[k] < DEPTH) m_cred[k]++;
    end
    if (acc) begin
      m_addr[e_tag] += 32'd16;
      m_rem[e_tag]--;
      m_last = e_tag;
      m_reqs++;
    end
    if (m_phase == 0 && start) begin
      for (int k = 0; k < NL; k++) begin
        m_addr[k] = run_base[k*AW +: AW];
        m_rem[k]  = int'(run_len[k*LW +: LW]);
        m_cred[k] = DEPTH;
      end
      m_last = NL - 1; m_stall = 0; m_reqs = 0;
    end
    m_phase = nphase;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    s_valid = req_valid; s_tag = int'(req_tag); s_addr = req_addr; s_busy = busy; s_done = done;
    if (req_valid && ready) begin
      dut_tags.push_back(req_tag);
      dut_addrs.push_back(req_addr);
    end
    if (done) done_seen++;
    @(posedge clk);
    model_update();
    #1;
    start = 1'b0;
    deq = '0;
    resp_valid = auto_resp && m_acc;
    resp_tag = 2'(m_acc_tag);
  endtask

  task automatic new_pass(input logic [NL*AW-1:0] b, input logic [NL*LW-1:0] l);
    run_base = b; run_len = l;
    dut_tags.delete(); dut_addrs.delete();
    done_seen = 0;
    start = 1'b1;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b1; resp_valid = 1'b0; resp_tag = 2'd0; deq = '0;
    run_base = '0; run_len = '0; auto_resp = 1'b0;
    m_phase = 0; m_out = 0; m_last = 0; m_stall = 0; m_reqs = 0; m_held = 0; m_acc = 0; m_acc_tag = 0;
    for (int k = 0; k < NL; k++) begin m_rem[k] = 0; m_cred[k] = 0; m_addr[k] = '0; end
    done_seen = 0;

    cycle(); cycle();
    chk("reset_valid", s_valid, 0);
    chk("reset_busy", s_busy, 0);
    rst_n = 1'b1;
    cycle();

    // Four runs of three beats, immediate responses, leaf 3 wraps the address space
    auto_resp = 1'b1; ready = 1'b1;
    new_pass({32'hFFFF_FFF0, 32'h3000, 32'h2000, 32'h1000}, {4{32'd3}});
    repeat (20) cycle();
    chk("t1_req_total", dut_tags.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < dut_tags.size()) begin
        chk("t1_tag_order", dut_tags[i], exp_tags1[i]);
        chk("t1_addr_order", dut_addrs[i], exp_addrs1[i]);
      end
    end
    chk("t1_done_once", done_seen, 1);

    // Credit limit: leaf 0 alone, no responses, no dequeues
    auto_resp = 1'b0;
    new_pass({96'h0, 32'h100}, {96'h0, 32'd20});
    repeat (14) cycle();
    chk("t2_req_at_credit_limit", dut_tags.size(), 8);
    chk("t2_valid_blocked", s_valid, 0);
    deq = 4'b0001;
    cycle();
    repeat (4) cycle();
    chk("t2_one_more_req", dut_tags.size(), 9);
    if (dut_addrs.size() > 8) chk("t2_ninth_addr", dut_addrs[8], 32'h180);
`ifdef LEAF_REFILL_STATS_EN
    chk("t2_req_count", req_count, 9);
`endif
    rst_n = 1'b0; cycle(); rst_n = 1'b1; cycle();
    chk("t2_reset_idle", s_busy, 0);

    // Five-cycle backpressure right after the first accept
    auto_resp = 1'b1; ready = 1'b1;
    new_pass({32'h7000, 32'h6000, 32'h5000, 32'h4000}, {4{32'd2}});
    cycle();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_stall_tag", s_tag, 1);
      chk("t3_stall_addr", s_addr, 32'h5000);
    end
    ready = 1'b1;
    repeat (20) cycle();
    chk("t3_done_once", done_seen, 1);
`ifdef LEAF_REFILL_STATS_EN
    chk("t3_stall_total", stall_cycles, 5);
    chk("t3_req_total", req_count, 8);
`endif

    // Empty pass: done three cycles after start
    new_pass('0, '0);
    done_at = -1;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (s_done && done_at < 0) done_at = i;
    end
    chk("t4_done_latency", done_at, 3);
    chk("t4_no_requests", dut_tags.size(), 0);

    // Reset with four reads outstanding, then a late response and a clean pass
    auto_resp = 1'b0;
    new_pass({32'h8300, 32'h8200, 32'h8100, 32'h8000}, {4{32'd5}});
    repeat (4) cycle();
    chk("t5_outstanding_reqs", dut_tags.size(), 4);
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    resp_valid = 1'b1; resp_tag = 2'd2;
    cycle();
    chk("t5_after_reset_valid", s_valid, 0);
    chk("t5_after_reset_busy", s_busy, 0);
    auto_resp = 1'b1;
    new_pass({32'h9300, 32'h9200, 32'h9100, 32'h9000}, {4{32'd1}});
    repeat (12) cycle();
    chk("t5_clean_reqs", dut_tags.size(), 4);
    if (dut_tags.size() > 3) chk("t5_clean_last_tag", dut_tags[3], 2'd3);
    chk("t5_clean_done", done_seen, 1);

    // Same-cycle accept and dequeue on leaf 2 at credit 1
    auto_resp = 1'b0;
    new_pass({32'h0, 32'hA000, 64'h0}, {32'd0, 32'd10, 64'd0});
    repeat (7) cycle();
    deq = 4'b0100;
    cycle();
    cycle();
    chk("t6_leaf2_still_valid", s_valid, 1);
    chk("t6_leaf2_tag", s_tag, 2);
    rst_n = 1'b0; cycle(); rst_n = 1'b1; cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
